// File: rtl/store_buf_if.sv
// Core-side request/response bundle for the store buffer front end.
// The core drives the master side; store_buf implements the slave side.
interface store_buf_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_adrs;
  logic [31:0] req_wdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        req_err;

  modport master (
    output req_valid, req_we, req_funct3, req_adrs, req_wdata,
    input  req_ready, ld_valid, ld_data, req_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_adrs, req_wdata,
    output req_ready, ld_valid, ld_data, req_err
  );
endinterface

// File: rtl/store_buf.sv
// Load/store front end: decodes RV32 funct3, queues stores in an in-order FIFO
// that drains into the memory write port, and stalls loads that touch a pending store.
module store_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  store_buf_if.slave  core,
  output logic        sb_empty,
  output logic [31:0] mem_adrs_rd,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byt_en,
  output logic        mem_sign_ext,
  output logic [31:0] mem_adrs_wr,
  output logic [31:0] mem_wr_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] adrs;
    logic [3:0]  byt_en;
    logic [31:0] wdata;
  } sb_entry_t;

  sb_entry_t       fifo_q [DEPTH];
  sb_entry_t       head;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic [3:0]      dec_be;
  logic [2:0]      dec_size;
  logic            legal;
  logic            overlap;
  logic            full;
  logic            empty;
  logic            handshake;
  logic            load_go;
  logic            push;
  logic            drain;

  // Byte count covered by a contiguous, right-aligned byte-enable mask.
  function automatic logic [2:0] be_size(input logic [3:0] be);
    case (be)
      4'b0001: be_size = 3'd1;
      4'b0011: be_size = 3'd2;
      default: be_size = 3'd4;
    endcase
  endfunction

  // funct3 decode: access width and legality for the request direction.
  always_comb begin
    dec_be   = 4'b0000;
    dec_size = 3'd4;
    case (core.req_funct3[1:0])
      2'b00:   begin dec_be = 4'b0001; dec_size = 3'd1; end
      2'b01:   begin dec_be = 4'b0011; dec_size = 3'd2; end
      2'b10:   begin dec_be = 4'b1111; dec_size = 3'd4; end
      default: begin dec_be = 4'b0000; dec_size = 3'd4; end
    endcase
    if (core.req_we) begin
      legal = (core.req_funct3[2] == 1'b0) && (core.req_funct3[1:0] != 2'b11);
    end else begin
      legal = (core.req_funct3[1:0] != 2'b11) &&
              !(core.req_funct3[2] && (core.req_funct3[1:0] == 2'b10));
    end
  end

  // Byte-range intersection against every live entry; 33-bit ends avoid wrap aliasing.
  always_comb begin
    overlap = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr_q)) < count_q) &&
          ({1'b0, core.req_adrs} <
           ({1'b0, fifo_q[i].adrs} + 33'(be_size(fifo_q[i].byt_en)))) &&
          ({1'b0, fifo_q[i].adrs} < ({1'b0, core.req_adrs} + 33'(dec_size)))) begin
        overlap = 1'b1;
      end
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head      = fifo_q[rd_ptr_q];

  // Stores are always accepted: a full FIFO drains in the same cycle.
  assign core.req_ready = core.req_we ? 1'b1 : (!full && !(legal && overlap));

  assign handshake = core.req_valid && core.req_ready;
  assign load_go   = handshake && !core.req_we && legal;
  assign push      = handshake && core.req_we && legal;
  assign drain     = !empty && !load_go;
  assign count_d   = count_q + CW'(push) - CW'(drain);

  // Memory port carries either the issuing load or the FIFO head, never both.
  always_comb begin
    mem_adrs_rd  = '0;
    mem_wr_en    = 1'b0;
    mem_byt_en   = 4'b0000;
    mem_sign_ext = 1'b0;
    mem_adrs_wr  = '0;
    mem_wr_data  = '0;
    if (load_go) begin
      mem_adrs_rd  = core.req_adrs;
      mem_byt_en   = dec_be;
      mem_sign_ext = !core.req_funct3[2];
    end else if (drain) begin
      mem_wr_en    = 1'b1;
      mem_adrs_wr  = head.adrs;
      mem_byt_en   = head.byt_en;
      mem_wr_data  = head.wdata;
    end
  end

  // Entry storage carries no reset; liveness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q].adrs   <= core.req_adrs;
      fifo_q[wr_ptr_q].byt_en <= dec_be;
      fifo_q[wr_ptr_q].wdata  <= core.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sb_empty      <= 1'b1;
      core.ld_valid <= 1'b0;
      core.ld_data  <= '0;
      core.req_err  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (drain) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q       <= count_d;
      sb_empty      <= (count_d == '0);
      core.ld_valid <= load_go;
      if (load_go) begin
        core.ld_data <= mem_rd_data;
      end
      core.req_err  <= handshake && !legal;
    end
  end

endmodule

// File: doc/store_buf.md
# store_buf

Store buffer and load/store front end placed directly upstream of the 1 KB byte-addressable data memory. It accepts core load/store requests, decodes RV32 `funct3` into the memory's byte-enable and sign-extension controls, and queues stores in a FIFO that drains into the memory write port. Loads go straight to the memory read port and return after one cycle. A load stalls while it overlaps any pending store, so every load observes all older stores.

## Interface
- `DEPTH`, 4: store FIFO entries, a power of two, at least 2.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a request is presented.
- `req_ready`  out  1: the request is accepted this cycle (handshake = `req_valid && req_ready`).
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32 access type.
- `req_adrs`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `ld_valid`  out  1: one-cycle pulse; `ld_data` is valid.
- `ld_data`  out  32: load result, already extended.
- `req_err`  out  1: one-cycle pulse; the previously accepted request had an illegal `funct3`.
- `sb_empty`  out  1: no pending stores.
- `mem_adrs_rd`  out  32: memory read address.
- `mem_rd_data`  in  32: memory read data; combinational from `mem_adrs_rd`, `mem_byt_en` and `mem_sign_ext`.
- `mem_wr_en`  out  1: memory write enable.
- `mem_byt_en`  out  4: byte enables. Shared by read and write.
- `mem_sign_ext`  out  1: sign-extension control for memory reads.
- `mem_adrs_wr`  out  32: memory write address.
- `mem_wr_data`  out  32: memory write data.

## Operation
- **Decode**
  - Byte enables: `funct3[1:0]` 00 gives 0001, 01 gives 0011, 10 gives 1111.
  - Loads: `mem_sign_ext` = !`funct3[2]`.
  - Legal loads: 000, 001, 010, 100, 101.
  - Legal stores: 000, 001, 010.
- **Illegal funct3**
  - The request is accepted but has no effect: no FIFO push, no memory access, no `ld_valid`.
  - `req_err` pulses on the next cycle.
- **FIFO entry** holds {adrs[31:0], byt_en[3:0], wdata[31:0]}. Circular read/write pointers with a count of 0..`DEPTH`. Pointers wrap modulo `DEPTH`.
- **Port sharing:** the memory port carries either a load read or a store drain in a given cycle, never both, because `byt_en` is shared.
  - `load_go` = `req_valid && !req_we && req_ready && legal`.
  - `drain` = !empty && !`load_go`.
- **Load cycle** (`load_go`):
  - `mem_adrs_rd` = `req_adrs`; `mem_byt_en` and `mem_sign_ext` come from decode.
  - `mem_wr_en` = 0.
  - `mem_rd_data` is registered into `ld_data`, and `ld_valid` = 1 on the next cycle.
- **Drain cycle:**
  - `mem_wr_en` = 1; `mem_adrs_wr`, `mem_byt_en` and `mem_wr_data` come from the head entry.
  - The head is popped at the clock edge.
- **Idle:** `mem_wr_en` = 0, `mem_byt_en` = 0000, `mem_sign_ext` = 0, `mem_adrs_rd` = `mem_adrs_wr` = 0, `mem_wr_data` = 0.
- **Load ready**
  - `req_ready` = !full && !overlap.
  - `overlap` is true when the load byte range [A, A+n−1] intersects any valid entry range [E, E+m−1]. n and m are 1, 2 or 4.
  - The comparison uses 33-bit end arithmetic, with no modulo-1024 aliasing.
  - While stalled, the FIFO drains one entry per cycle. When overlap clears, the load issues in the same cycle.
  - The full-FIFO stall guarantees drain progress under back-to-back loads.
- **Store ready**
  - `req_ready` = 1. The FIFO is either not full, or it drains this cycle (no load can coexist).
  - A store and a drain in the same cycle cause a simultaneous push and pop; count is unchanged.
  - A store pushed into an empty FIFO drains no earlier than the next cycle. There is no bypass.
- **Store ordering:** stores drain strictly in acceptance order. There is no store-to-store merging.

## Timing
- **Load latency:** accept in cycle N, `ld_valid`/`ld_data` in cycle N+1. Sustained one load per cycle when there is no overlap and the FIFO is not full.
- **Store visibility:** memory is updated at the end of the drain cycle. Best case is acceptance in N and memory written at the edge ending N+1.
- **Combinational paths:**
  - `req_ready` depends on the request fields and FIFO state.
  - The memory controls are combinational from the request and the FIFO head.
- **Reset** (synchronous, `rst` high at an edge):
  - Count and pointers = 0, `sb_empty` = 1.
  - `ld_valid` = 0, `ld_data` = 0, `req_err` = 0.
  - Pending stores are discarded.
  - A load accepted in the reset cycle produces no `ld_valid`.
- **`sb_empty`** is registered state (count == 0). It goes high the cycle after the last pop.

## Test plan
- **Store then load, same address:** SW 0xDEADBEEF @0x10 in cycle 0, then LW @0x10 in cycle 1. The load stalls one cycle (overlap), issues in cycle 2, and gives `ld_data` = 0xDEADBEEF in cycle 3.
- **Sign handling:** memory byte @0x20 = 0x80. LB gives 0xFFFFFF80 and LBU gives 0x00000080. SH 0x8001 @0x30 followed by LH @0x30 gives 0xFFFF8001.
- **Full FIFO:**
  - Stimulus: 4 SW to distinct addresses back-to-back, then continuous non-overlapping LW.
  - Response: the load is blocked while count = 4; one drain per blocked cycle; all stores reach memory in order.
- **Partial overlap:** pending SW @0x40, then LB @0x43. The load stalls until the FIFO is empty. LB @0x44 issues immediately with no stall.
- **Illegal funct3:** store with funct3 = 011 gives `req_err` = 1 for one cycle, no FIFO push, memory unchanged. Load funct3 = 110 gives `req_err` = 1 and no `ld_valid`.
- **Reset mid-operation:** with 3 stores pending and a load accepted, assert `rst`. Next cycle: `sb_empty` = 1, `ld_valid` = 0, no further memory writes.
